// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, constants and width helpers for the instruction cache
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FILL  = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0;

    function automatic int index_w(input int lines);
        return $clog2(lines);
    endfunction

    // Two low address bits select a byte within the word and take no part in the lookup.
    function automatic int tag_w(input int addr_w, input int lines);
        return addr_w - $clog2(lines) - 2;
    endfunction

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid bits, tag RAM and data RAM with combinational read and one write port
module icache_array #(
    parameter int LINES   = 16,
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 10,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_we,
    input  logic [INDEX_W-1:0] i_widx,
    input  logic [TAG_W-1:0]   i_wtag,
    input  logic [DATA_W-1:0]  i_wdata,
    input  logic [INDEX_W-1:0] i_ridx,
    output logic               o_valid,
    output logic [TAG_W-1:0]   o_tag,
    output logic [DATA_W-1:0]  o_data
);

    logic [LINES-1:0]  r_valid;
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [DATA_W-1:0] r_data [LINES];

    // Clear wins over a write so a flush can never leave a stale line marked valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_clear) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end

    assign o_valid = r_valid[i_ridx];
    assign o_tag   = r_tag[i_ridx];
    assign o_data  = r_data[i_ridx];

endmodule

// File: rtl/icache_ctrl.sv
// rtl/icache_ctrl.sv - direct-mapped instruction cache controller: lookup, miss refill FSM, hit/miss counters
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int LINES   = 16,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              flush,
    output logic [DATA_W-1:0] instr_out,
    output logic              stall,
    output logic [ADDR_W-1:0] IM_Address,
    output logic              IM_en_Read,
    input  logic [DATA_W-1:0] Instruction,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    localparam int INDEX_W = index_w(LINES);
    localparam int TAG_W   = tag_w(ADDR_W, LINES);
    localparam int LAT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_miss_addr;
    logic [LAT_W-1:0]   r_lat;
    logic               r_flush_pend;
    logic [CNT_W-1:0]   r_hit_cnt;
    logic [CNT_W-1:0]   r_miss_cnt;

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic               w_line_valid;
    logic [TAG_W-1:0]   w_line_tag;
    logic [DATA_W-1:0]  w_line_data;
    logic               w_hit;
    logic               w_miss;
    logic               w_we;
    logic               w_clear;

    assign w_index = cpu_addr[INDEX_W+1:2];
    assign w_tag   = cpu_addr[ADDR_W-1:INDEX_W+2];

    icache_array #(
        .LINES   (LINES),
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst),
        .i_clear (w_clear),
        .i_we    (w_we),
        .i_widx  (r_miss_addr[INDEX_W+1:2]),
        .i_wtag  (r_miss_addr[ADDR_W-1:INDEX_W+2]),
        .i_wdata (Instruction),
        .i_ridx  (w_index),
        .o_valid (w_line_valid),
        .o_tag   (w_line_tag),
        .o_data  (w_line_data)
    );

    always_comb begin
        w_next  = r_state;
        w_hit   = 1'b0;
        w_miss  = 1'b0;
        w_we    = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            IDLE: begin
                // A flush deferred from a refill is applied here, after the line was written.
                w_clear = flush || r_flush_pend;
                if (cpu_req) begin
                    if (w_line_valid && (w_line_tag == w_tag)) begin
                        w_hit = 1'b1;
                    end else begin
                        w_miss = 1'b1;
                        w_next = FETCH;
                    end
                end
            end
            FETCH: begin
                if (r_lat == '0) begin
                    w_next = FILL;
                end
            end
            FILL: begin
                w_we   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_miss_addr  <= '0;
            r_lat        <= '0;
            r_flush_pend <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_miss) begin
                r_miss_addr <= cpu_addr;
                r_lat       <= LAT_W'(MEM_LAT - 1);
            end else if ((r_state == FETCH) && (r_lat != '0)) begin
                r_lat <= r_lat - 1'b1;
            end
            if (w_clear) begin
                r_flush_pend <= 1'b0;
            end else if (flush && (r_state != IDLE)) begin
                r_flush_pend <= 1'b1;
            end
            if (w_hit && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
            end
            if (w_miss && (r_miss_cnt != '1)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
            end
        end
    end

    assign instr_out  = w_hit ? w_line_data : DATA_W'(NOP);
    assign stall      = rst && (w_miss || (r_state != IDLE));
    assign IM_en_Read = (r_state == FETCH);
    assign IM_Address = r_miss_addr;
    assign hit_cnt    = r_hit_cnt;
    assign miss_cnt   = r_miss_cnt;

endmodule

// File: tb/tb_icache_ctrl.sv
// tb/tb_icache_ctrl.sv - self-checking bench for icache_ctrl with a transaction-level cache model
module tb_icache_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        flush;
    logic [31:0] Instruction;
    logic [31:0] instr_out;
    logic        stall;
    logic [15:0] IM_Address;
    logic        IM_en_Read;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    logic [31:0] instr_out4;
    logic        stall4;
    logic [15:0] IM_Address4;
    logic        IM_en_Read4;
    logic [3:0]  hit_cnt4;
    logic [3:0]  miss_cnt4;

    int checks = 0;
    int errors = 0;

    logic [15:0] mv;
    logic [9:0]  mtag [16];
    int          mh;
    int          mm;

    icache_ctrl dut (
        .clk (clk), .rst (rst), .cpu_req (cpu_req), .cpu_addr (cpu_addr), .flush (flush),
        .instr_out (instr_out), .stall (stall), .IM_Address (IM_Address), .IM_en_Read (IM_en_Read),
        .Instruction (Instruction), .hit_cnt (hit_cnt), .miss_cnt (miss_cnt)
    );

    icache_ctrl #(.CNT_W (4)) dut4 (
        .clk (clk), .rst (rst), .cpu_req (cpu_req), .cpu_addr (cpu_addr), .flush (flush),
        .instr_out (instr_out4), .stall (stall4), .IM_Address (IM_Address4), .IM_en_Read (IM_en_Read4),
        .Instruction (Instruction), .hit_cnt (hit_cnt4), .miss_cnt (miss_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] im_word(input logic [15:0] a);
        logic [15:0] w;
        w = {a[15:2], 2'b00};
        return {w ^ 16'hC3A5, ~w};
    endfunction

    // Word-addressed instruction memory with one cycle of read latency.
    always @(posedge clk) begin
        Instruction <= IM_en_Read ? im_word(IM_Address) : 32'hDEAD_BEEF;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mv = '0;
        mh = 0;
        mm = 0;
    endtask

    task automatic idle_cycle(input logic fl);
        cpu_req = 1'b0;
        flush   = fl;
        @(negedge clk);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_instr", instr_out, 32'd0);
        tick();
        flush = 1'b0;
        if (fl) mv = '0;
    endtask

    // fl: 0 no flush, 1 flush in the lookup cycle, 2 flush during the refill
    task automatic do_fetch(input logic [15:0] a, input int fl);
        int          idx;
        int          n;
        int          ims;
        logic [9:0]  tg;
        logic        hit;
        idx = int'(a[5:2]);
        tg  = a[15:6];
        hit = mv[idx] && (mtag[idx] == tg);
        cpu_req  = 1'b1;
        cpu_addr = a;
        flush    = (fl == 1);
        @(negedge clk);
        chk("lookup_stall", 32'(stall), 32'(!hit));
        chk("lookup_instr", instr_out, hit ? im_word(a) : 32'd0);
        if (hit) begin
            mh++;
            tick();
            flush = 1'b0;
            if (fl == 1) mv = '0;
        end else begin
            mm++;
            if (fl == 1) mv = '0;
            n   = 1;
            ims = 0;
            tick();
            flush = (fl == 2);
            @(negedge clk);
            while (stall && n < 20) begin
                n++;
                if (IM_en_Read) begin
                    ims++;
                    chk("im_address", 32'(IM_Address), 32'(a));
                end
                tick();
                flush = 1'b0;
                @(negedge clk);
            end
            chk("miss_penalty", n, 3);
            chk("im_read_cycles", ims, 1);
            chk("replay_instr", instr_out, im_word(a));
            mv[idx]   = 1'b1;
            mtag[idx] = tg;
            mh++;
            tick();
            flush = 1'b0;
            if (fl == 2) mv = '0;
        end
        chk("hit_cnt", 32'(hit_cnt), 32'(mh));
        chk("miss_cnt", 32'(miss_cnt), 32'(mm));
    endtask

    typedef struct {
        logic        req;
        logic [15:0] addr;
        logic        exp_stall;
        logic        exp_data;
        logic        exp_im_en;
        logic [15:0] exp_im_addr;
        int          exp_h;
        int          exp_m;
    } vec_t;

    function automatic vec_t mk(input logic req, input logic [15:0] addr, input logic st,
                                input logic dv, input logic en, input logic [15:0] ima,
                                input int h, input int m);
        vec_t v;
        v.req = req; v.addr = addr; v.exp_stall = st; v.exp_data = dv;
        v.exp_im_en = en; v.exp_im_addr = ima; v.exp_h = h; v.exp_m = m;
        return v;
    endfunction

    initial begin
        vec_t vecs[14];
        logic [15:0] ra;
        int r;

        vecs[0]  = mk(1, 16'h0000, 1, 0, 0, 16'h0000, 0, 0);
        vecs[1]  = mk(1, 16'h0000, 1, 0, 1, 16'h0000, 0, 1);
        vecs[2]  = mk(1, 16'h0000, 1, 0, 0, 16'h0000, 0, 1);
        vecs[3]  = mk(1, 16'h0000, 0, 1, 0, 16'h0000, 0, 1);
        vecs[4]  = mk(1, 16'h0000, 0, 1, 0, 16'h0000, 1, 1);
        vecs[5]  = mk(1, 16'h0040, 1, 0, 0, 16'h0000, 2, 1);
        vecs[6]  = mk(1, 16'h0040, 1, 0, 1, 16'h0040, 2, 2);
        vecs[7]  = mk(1, 16'h0040, 1, 0, 0, 16'h0040, 2, 2);
        vecs[8]  = mk(1, 16'h0040, 0, 1, 0, 16'h0040, 2, 2);
        vecs[9]  = mk(1, 16'h0000, 1, 0, 0, 16'h0040, 3, 2);
        vecs[10] = mk(1, 16'h0000, 1, 0, 1, 16'h0000, 3, 3);
        vecs[11] = mk(1, 16'h0000, 1, 0, 0, 16'h0000, 3, 3);
        vecs[12] = mk(1, 16'h0000, 0, 1, 0, 16'h0000, 3, 3);
        vecs[13] = mk(0, 16'h0000, 0, 0, 0, 16'h0000, 4, 3);

        rst      = 1'b0;
        cpu_req  = 1'b1;
        cpu_addr = 16'h0000;
        flush    = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_im_en", 32'(IM_en_Read), 32'd0);
        chk("rst_im_addr", 32'(IM_Address), 32'd0);
        chk("rst_instr", instr_out, 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        tick();
        rst = 1'b1;

        // Cold miss, hit, and index-0 conflict eviction, cycle by cycle.
        for (int i = 0; i < 14; i++) begin
            cpu_req  = vecs[i].req;
            cpu_addr = vecs[i].addr;
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
            chk($sformatf("v%0d_instr", i), instr_out, vecs[i].exp_data ? im_word(vecs[i].addr) : 32'd0);
            chk($sformatf("v%0d_im_en", i), 32'(IM_en_Read), 32'(vecs[i].exp_im_en));
            chk($sformatf("v%0d_im_addr", i), 32'(IM_Address), 32'(vecs[i].exp_im_addr));
            chk($sformatf("v%0d_hit_cnt", i), 32'(hit_cnt), 32'(vecs[i].exp_h));
            chk($sformatf("v%0d_miss_cnt", i), 32'(miss_cnt), 32'(vecs[i].exp_m));
            tick();
        end
        mv[0]   = 1'b1;
        mtag[0] = 10'd0;
        mh      = 4;
        mm      = 3;

        // Flush during a refill: the replay hits, then the whole cache is invalid.
        do_fetch(16'h0004, 2);
        do_fetch(16'h0004, 0);
        do_fetch(16'h0000, 1);
        do_fetch(16'h0000, 0);
        idle_cycle(1'b1);

        // Reset in the middle of a refill.
        cpu_req  = 1'b1;
        cpu_addr = 16'h0000;
        tick();
        chk("midfetch_im_en", 32'(IM_en_Read), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_stall", 32'(stall), 32'd0);
        chk("abort_im_en", 32'(IM_en_Read), 32'd0);
        chk("abort_instr", instr_out, 32'd0);
        @(negedge clk);
        chk("abort_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("abort_miss_cnt", 32'(miss_cnt), 32'd0);
        cpu_req = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        do_fetch(16'h0000, 0);

        // Counter saturation on the 4-bit instance.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_reset();
        do_fetch(16'h0008, 0);
        for (int i = 0; i < 20; i++) begin
            do_fetch(16'h0008, 0);
        end
        chk("sat_hit_cnt4", 32'(hit_cnt4), 32'hF);
        chk("sat_miss_cnt4", 32'(miss_cnt4), 32'd1);
        chk("sat_hit_cnt16", 32'(hit_cnt), 32'd21);
        chk("sat_im_addr4", 32'(IM_Address4), 32'h0008);
        cpu_req  = 1'b1;
        cpu_addr = 16'h0008;
        @(negedge clk);
        chk("sat_instr4", instr_out4, im_word(16'h0008));
        chk("sat_stall4", 32'(stall4), 32'd0);
        chk("sat_im_en4", 32'(IM_en_Read4), 32'd0);
        tick();
        mh++;

        // Random traffic over a small address pool to mix hits, misses, conflicts and flushes.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                idle_cycle($urandom_range(0, 3) == 0);
            end
            ra = 16'(($urandom_range(0, 2) << 6) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
            r  = $urandom_range(0, 19);
            do_fetch(ra, (r == 0) ? 1 : ((r == 1) ? 2 : 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
